vga_rx_decode: RTL

- Receive-side counterpart of the VGA timing generator.
- Consumes hsync/vsync/rgb_valid/pixel data as produced by the generator, running in the same vga_clk domain.
- Measures the incoming timing, recovers pixel coordinates, and declares lock when the timing matches the configured mode.
- Feeds loopback self-test and a frame-capture path in the FPGA lab design.

---
 rtl/vga_rx_decode.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_decode.sv
`timescale 1ns/1ps
// vga_rx_decode
// -----------------------------------------------------------------------------
// Receive-side decoder for a VGA-style timing stream in the vga_clk domain.
// It measures line/frame geometry, recovers pixel coordinates and declares
// lock once a full frame matches the configured mode.
//
// Ports:
//   vga_clk        pixel clock
//   sys_rst_n      asynchronous active-low reset
//   hsync_in       horizontal sync (asserted level = SYNC_POL)
//   vsync_in       vertical sync   (asserted level = SYNC_POL)
//   rgb_valid_in   active-video qualifier
//   pix_data_in    RGB565 pixel
//   pix_valid_out  recovered pixel strobe (2 clocks after the input)
//   pix_x_out      recovered column of the pixel on pix_data_out
//   pix_y_out      recovered active-line index of that pixel
//   pix_data_out   pixel aligned with pix_valid_out
//   frame_start    one-cycle pulse per vsync leading edge (meas_v_* update cycle)
//   meas_h_total   clocks between the last two hsync leading edges
//   meas_v_total   lines in the last frame
//   meas_h_active  rgb_valid clocks in the last line that carried video
//   meas_v_active  active lines in the last frame
//   locked         timing matches the parameters
//   err_pulse      one-cycle pulse on a timing violation while locked
//   err_cnt        saturating violation count
//
// Handshake: there is no back-pressure. pix_valid_out qualifies pix_x_out,
// pix_y_out and pix_data_out for exactly the cycle it is high; consumers must
// additionally gate on locked before trusting the coordinates.
// -----------------------------------------------------------------------------
module vga_rx_decode #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned TIMEOUT  = 1600
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        rgb_valid_in,
  input  logic [15:0] pix_data_in,
  output logic        pix_valid_out,
  output logic [9:0]  pix_x_out,
  output logic [9:0]  pix_y_out,
  output logic [15:0] pix_data_out,
  output logic        frame_start,
  output logic [11:0] meas_h_total,
  output logic [10:0] meas_v_total,
  output logic [10:0] meas_h_active,
  output logic [9:0]  meas_v_active,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input capture: stage 1 is the only copy of the inputs the logic uses;
  // stage 2 holds the previous sync levels for edge detection.
  // ---------------------------------------------------------------------------
  logic        s1_hs, s1_vs, s1_rv;
  logic [15:0] s1_pd;
  logic        s2_hs, s2_vs;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_rv <= 1'b0;
      s1_pd <= 16'd0;
      s2_hs <= 1'b0;
      s2_vs <= 1'b0;
    end else begin
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
      s1_rv <= rgb_valid_in;
      s1_pd <= pix_data_in;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
    end
  end

  // Leading edge = transition into the asserted sync level.
  logic hs_edge, vs_edge;
  assign hs_edge = (s1_hs == SYNC_POL) && (s2_hs != SYNC_POL);
  assign vs_edge = (s1_vs == SYNC_POL) && (s2_vs != SYNC_POL);

  // ---------------------------------------------------------------------------
  // Horizontal measurement
  // ---------------------------------------------------------------------------
  logic [11:0] cnt_h;
  logic [10:0] cnt_a;
  logic [10:0] line_a;   // active count of the line just closed by an hsync edge

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h        <= 12'd0;
      meas_h_total <= 12'd0;
    end else if (hs_edge) begin
      cnt_h        <= 12'd0;
      meas_h_total <= (cnt_h == 12'hFFF) ? 12'hFFF : cnt_h + 12'd1;
    end else if (cnt_h != 12'hFFF) begin
      cnt_h <= cnt_h + 12'd1;
    end
  end

  // meas_h_active only follows lines that carried video, so that at a vsync
  // edge (closing a blanking line) it still reports the real active width.
  // The per-line value used by the violation check is kept in line_a.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_a         <= 11'd0;
      line_a        <= 11'd0;
      meas_h_active <= 11'd0;
    end else if (hs_edge) begin
      line_a <= cnt_a;
      if (cnt_a != 11'd0) begin
        meas_h_active <= cnt_a;
      end
      // A pixel coincident with the edge is the first pixel of the new line.
      cnt_a <= {10'd0, s1_rv};
    end else if (s1_rv && (cnt_a != 11'h7FF)) begin
      cnt_a <= cnt_a + 11'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Vertical measurement. A vsync edge that coincides with an hsync edge is
  // treated purely as the vsync edge.
  // ---------------------------------------------------------------------------
  logic [10:0] cnt_l;
  logic [9:0]  cnt_v;
  logic [9:0]  cnt_v_nxt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_l        <= 11'd0;
      meas_v_total <= 11'd0;
    end else if (vs_edge) begin
      cnt_l        <= 11'd0;
      meas_v_total <= (cnt_l == 11'h7FF) ? 11'h7FF : cnt_l + 11'd1;
    end else if (hs_edge && (cnt_l != 11'h7FF)) begin
      cnt_l <= cnt_l + 11'd1;
    end
  end

  always_comb begin
    cnt_v_nxt = cnt_v;
    if (vs_edge) begin
      cnt_v_nxt = 10'd0;
    end else if (hs_edge && (cnt_a != 11'd0) && (cnt_v != 10'h3FF)) begin
      cnt_v_nxt = cnt_v + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_v         <= 10'd0;
      meas_v_active <= 10'd0;
    end else begin
      cnt_v <= cnt_v_nxt;
      if (vs_edge) begin
        meas_v_active <= cnt_v;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel path: second register stage after input capture. Coordinates are the
  // post-edge indices so a pixel on an edge cycle lands at x=0 / new y.
  // ---------------------------------------------------------------------------
  logic [9:0] pix_x_cur;
  assign pix_x_cur = hs_edge   ? 10'd0 :
                     cnt_a[10] ? 10'h3FF : cnt_a[9:0];

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_valid_out <= 1'b0;
      pix_x_out     <= 10'd0;
      pix_y_out     <= 10'd0;
      pix_data_out  <= 16'd0;
    end else begin
      pix_valid_out <= s1_rv;
      pix_x_out     <= pix_x_cur;
      pix_y_out     <= cnt_v_nxt;
      pix_data_out  <= s1_pd;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge flags delayed one cycle so every check sees the updated meas_* values.
  // frame_start doubles as the delayed vsync edge flag.
  // ---------------------------------------------------------------------------
  logic hs_d;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_d        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_d        <= hs_edge;
      frame_start <= vs_edge;
    end
  end

  // Zero-extended comparisons against the configured mode.
  logic timeout;
  logic h_total_ok, h_act_ok, v_total_ok, v_act_ok, line_ok;
  logic meas_match, viol;

  assign timeout    = ({20'd0, cnt_h} == TIMEOUT);
  assign h_total_ok = ({20'd0, meas_h_total} == H_TOTAL);
  assign h_act_ok   = ({21'd0, meas_h_active} == H_ACTIVE);
  assign v_total_ok = ({21'd0, meas_v_total} == V_TOTAL);
  assign v_act_ok   = ({22'd0, meas_v_active} == V_ACTIVE);
  assign line_ok    = (line_a == 11'd0) || ({21'd0, line_a} == H_ACTIVE);
  assign meas_match = h_total_ok && h_act_ok && v_total_ok && v_act_ok;

  // Any combination of simultaneous violations collapses into one event.
  // The line closed by a vsync edge is the final line and is exempt from
  // the active-width check.
  assign viol = timeout
             || (hs_d && !h_total_ok)
             || (hs_d && !frame_start && !line_ok)
             || (frame_start && !(v_total_ok && v_act_ok));

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t state, state_nxt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: begin
        if (!timeout && frame_start) begin
          state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (timeout) begin
          state_nxt = ST_SEARCH;
        end else if (frame_start && meas_match) begin
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (viol) begin
          state_nxt = ST_SEARCH;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    locked    = 1'b0;
    err_pulse = 1'b0;
    if (state == ST_LOCKED) begin
      locked    = 1'b1;
      err_pulse = viol;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_pulse && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
